// File: rtl/tag_window_counter.sv
// Purpose : counts rising-edge tags per channel over gap-free tagtime windows, one result per closed window.
// Latency : the closing tag in cycle N gives m_valid=1 with the closed result in cycle N+1. Counts update one cycle after a tag.
// Backpr. : the tag input never stalls. A close while a result is held and not accepted is dropped and counted in drop_count.
// Ports   : clk/rst (async active-low); tag stream valid_tag/tagtime/channel/rising_edge;
//           result register m_valid/m_ready/m_window_start/m_counts/m_overflow/m_resync; drop_count.
module tag_window_counter #(
    parameter int          CHANNELS    = 3,
    parameter logic [63:0] WINDOW      = 64'd40000,
    parameter int          COUNT_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            valid_tag,
    input  logic [63:0]                     tagtime,
    input  logic [4:0]                      channel,
    input  logic                            rising_edge,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [63:0]                     m_window_start,
    output logic [CHANNELS*COUNT_WIDTH-1:0] m_counts,
    output logic                            m_overflow,
    output logic                            m_resync,
    output logic [15:0]                     drop_count
);

    // Window limits are compared in 65 bits so that 2*WINDOW cannot wrap.
    localparam logic [64:0]            WIN1    = {1'b0, WINDOW};
    localparam logic [64:0]            WIN2    = {WINDOW, 1'b0};
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                   state;
    logic [63:0]              start;
    logic [COUNT_WIDTH-1:0]   cnt [CHANNELS];
    logic                     win_ovf;
    logic                     win_resync;

    logic                            counted;
    logic [63:0]                     delta;
    logic                            in_win;
    logic                            next_win;
    logic                            close;
    logic                            out_free;
    logic [CHANNELS*COUNT_WIDTH-1:0] cnt_flat;

    always_comb begin
        counted  = valid_tag && rising_edge && (int'(channel) < CHANNELS);
        // Modulo-2^64 difference, so tagtime wrap-around is harmless.
        delta    = tagtime - start;
        in_win   = {1'b0, delta} < WIN1;
        next_win = {1'b0, delta} < WIN2;
        close    = counted && (state == RUN) && !in_win;
        out_free = !m_valid || m_ready;
        cnt_flat = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            cnt_flat[k*COUNT_WIDTH +: COUNT_WIDTH] = cnt[k];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            start          <= '0;
            win_ovf        <= 1'b0;
            win_resync     <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                cnt[k] <= '0;
            end
            m_valid        <= 1'b0;
            m_window_start <= '0;
            m_counts       <= '0;
            m_overflow     <= 1'b0;
            m_resync       <= 1'b0;
            drop_count     <= '0;
        end else begin
            // Window state: open from IDLE, accumulate, or roll over on a close.
            if (counted) begin
                if (state == IDLE || !in_win) begin
                    for (int k = 0; k < CHANNELS; k++) begin
                        cnt[k] <= (int'(channel) == k) ? CNT_ONE : '0;
                    end
                    win_ovf <= 1'b0;
                    state   <= RUN;
                    if (state == IDLE || !next_win) begin
                        // Fresh timebase: intermediate empty windows are skipped.
                        start      <= tagtime;
                        win_resync <= 1'b1;
                    end else begin
                        start      <= start + WINDOW;
                        win_resync <= 1'b0;
                    end
                end else begin
                    for (int k = 0; k < CHANNELS; k++) begin
                        if (int'(channel) == k) begin
                            if (cnt[k] == CNT_MAX) begin
                                win_ovf <= 1'b1;
                            end else begin
                                cnt[k] <= cnt[k] + CNT_ONE;
                            end
                        end
                    end
                end
            end

            // Output register: a close loads it if it is empty or being drained this cycle.
            if (close) begin
                if (out_free) begin
                    m_valid        <= 1'b1;
                    m_window_start <= start;
                    m_counts       <= cnt_flat;
                    m_overflow     <= win_ovf;
                    m_resync       <= win_resync;
                end else if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tag_window_counter.sv
module tb_tag_window_counter;

    typedef struct packed {
        logic [63:0] start;
        logic [95:0] counts;
        logic        ovf;
        logic        resync;
    } res_t;

    typedef struct packed {
        logic [63:0] start;
        logic [8:0]  counts;
        logic        ovf;
        logic        resync;
    } res3_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    // Main instance (COUNT_WIDTH=32).
    logic        valid_tag = 1'b0;
    logic [63:0] tagtime = '0;
    logic [4:0]  channel = '0;
    logic        rising_edge = 1'b0;
    logic        m_ready = 1'b1;
    logic        m_valid;
    logic [63:0] m_window_start;
    logic [95:0] m_counts;
    logic        m_overflow;
    logic        m_resync;
    logic [15:0] drop_count;

    // Saturation instance (COUNT_WIDTH=3).
    logic        s_valid_tag = 1'b0;
    logic [63:0] s_tagtime = '0;
    logic [4:0]  s_channel = '0;
    logic        s_rising_edge = 1'b0;
    logic        s_ready = 1'b1;
    logic        s_valid;
    logic [63:0] s_window_start;
    logic [8:0]  s_counts;
    logic        s_overflow;
    logic        s_resync;
    logic [15:0] s_drop_count;

    int checks = 0;
    int failures = 0;

    res_t  sbq [$];
    res3_t sbq3 [$];

    always #5 clk = ~clk;

    tag_window_counter #(.CHANNELS(3), .WINDOW(64'd40000), .COUNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .valid_tag(valid_tag), .tagtime(tagtime), .channel(channel),
        .rising_edge(rising_edge), .m_valid(m_valid), .m_ready(m_ready),
        .m_window_start(m_window_start), .m_counts(m_counts), .m_overflow(m_overflow),
        .m_resync(m_resync), .drop_count(drop_count)
    );

    tag_window_counter #(.CHANNELS(3), .WINDOW(64'd40000), .COUNT_WIDTH(3)) dut_sat (
        .clk(clk), .rst(rst), .valid_tag(s_valid_tag), .tagtime(s_tagtime), .channel(s_channel),
        .rising_edge(s_rising_edge), .m_valid(s_valid), .m_ready(s_ready),
        .m_window_start(s_window_start), .m_counts(s_counts), .m_overflow(s_overflow),
        .m_resync(s_resync), .drop_count(s_drop_count)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] mk(input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] c2);
        return {c2, c1, c0};
    endfunction

    function automatic res_t exp_res(input logic [63:0] s, input logic [95:0] c, input logic o, input logic r);
        res_t x;
        x.start = s; x.counts = c; x.ovf = o; x.resync = r;
        return x;
    endfunction

    // Present one tag for one cycle; returns 1 time unit after the edge that samples it.
    task automatic send(input logic [63:0] t, input logic [4:0] ch, input logic r);
        valid_tag = 1'b1; tagtime = t; channel = ch; rising_edge = r;
        @(posedge clk); #1;
        valid_tag = 1'b0;
    endtask

    task automatic send_s(input logic [63:0] t, input logic [4:0] ch);
        s_valid_tag = 1'b1; s_tagtime = t; s_channel = ch; s_rising_edge = 1'b1;
        @(posedge clk); #1;
        s_valid_tag = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitors: compare every accepted result against the scoreboard front.
    always @(negedge clk) begin
        if (rst && m_valid && m_ready) begin
            if (sbq.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_result: start=%0d counts=0x%0h expected none", m_window_start, m_counts);
            end else begin
                res_t e;
                e = sbq.pop_front();
                chk("res_start", 128'(m_window_start), 128'(e.start));
                chk("res_counts", 128'(m_counts), 128'(e.counts));
                chk("res_overflow", 128'(m_overflow), 128'(e.ovf));
                chk("res_resync", 128'(m_resync), 128'(e.resync));
            end
        end
    end

    always @(negedge clk) begin
        if (rst && s_valid && s_ready) begin
            if (sbq3.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_sat_result: counts=0x%0h expected none", s_counts);
            end else begin
                res3_t e;
                e = sbq3.pop_front();
                chk("sat_start", 128'(s_window_start), 128'(e.start));
                chk("sat_counts", 128'(s_counts), 128'(e.counts));
                chk("sat_overflow", 128'(s_overflow), 128'(e.ovf));
                chk("sat_resync", 128'(s_resync), 128'(e.resync));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        res3_t e3;
        // Reset state.
        idle(3);
        chk("rst_m_valid", 128'(m_valid), 128'(0));
        chk("rst_drop", 128'(drop_count), 128'(0));
        rst = 1'b1;
        idle(1);
        chk("rst_start", 128'(m_window_start), 128'(0));
        chk("rst_counts", 128'(m_counts), 128'(0));
        chk("rst_flags", 128'({m_overflow, m_resync}), 128'(0));

        // Ignored tags never open a window from IDLE.
        send(64'd123, 5'd0, 1'b0);
        send(64'd456, 5'd5, 1'b1);

        // Basic window: ch0 every 4000 from 0 to 36000, closed by t=40000.
        for (int i = 0; i < 10; i++) send(64'(i * 4000), 5'd0, 1'b1);
        chk("no_result_before_close", 128'(m_valid), 128'(0));
        sbq.push_back(exp_res(64'd0, mk(10, 0, 0), 1'b0, 1'b1));
        send(64'd40000, 5'd0, 1'b1);
        chk("valid_after_close", 128'(m_valid), 128'(1));

        // Next window with ignored tags interleaved, plus ch1/ch2 activity.
        for (int i = 1; i < 10; i++) begin
            send(64'(40000 + i * 4000), 5'd0, 1'b1);
            send(64'(41000 + i * 4000), 5'd0, 1'b0);
            send(64'(42000 + i * 4000), 5'd5, 1'b1);
            if (i == 2) send(64'd50000, 5'd1, 1'b1);
            if (i == 5) begin
                send(64'd60000, 5'd2, 1'b1);
                send(64'd61000, 5'd2, 1'b1);
                send(64'd500000, 5'd1, 1'b0);
            end
        end
        sbq.push_back(exp_res(64'd40000, mk(10, 1, 2), 1'b0, 1'b0));
        send(64'd80000, 5'd0, 1'b1);

        // Time jump: window starting at 80000 is closed by t=200000.
        sbq.push_back(exp_res(64'd80000, mk(1, 0, 0), 1'b0, 1'b0));
        send(64'd200000, 5'd0, 1'b1);
        sbq.push_back(exp_res(64'd200000, mk(1, 0, 0), 1'b0, 1'b1));
        send(64'd240000, 5'd2, 1'b1);
        idle(2);

        // Backpressure: three closes with m_ready low.
        m_ready = 1'b0;
        sbq.push_back(exp_res(64'd240000, mk(0, 0, 1), 1'b0, 1'b0));
        send(64'd280000, 5'd1, 1'b1);
        send(64'd320000, 5'd0, 1'b1);
        send(64'd360000, 5'd0, 1'b1);
        chk("bp_drop_count", 128'(drop_count), 128'(2));
        chk("bp_held_valid", 128'(m_valid), 128'(1));
        chk("bp_held_start", 128'(m_window_start), 128'(240000));
        chk("bp_held_counts", 128'(m_counts), 128'(mk(0, 0, 1)));

        // Close coinciding with the handshake.
        m_ready = 1'b1;
        sbq.push_back(exp_res(64'd360000, mk(1, 0, 0), 1'b0, 1'b0));
        send(64'd400000, 5'd1, 1'b1);
        chk("hs_close_valid", 128'(m_valid), 128'(1));
        chk("hs_close_start", 128'(m_window_start), 128'(360000));
        idle(1);
        chk("hs_drained_valid", 128'(m_valid), 128'(0));

        // Saturation: 9 ch1 tags into a 3-bit counter.
        for (int i = 0; i < 9; i++) send_s(64'(i * 100), 5'd1);
        e3.start = 64'd0; e3.counts = {3'd0, 3'd7, 3'd0}; e3.ovf = 1'b1; e3.resync = 1'b1;
        sbq3.push_back(e3);
        send_s(64'd40000, 5'd0);
        idle(2);

        // Reset mid-window with a held result.
        m_ready = 1'b0;
        sbq.push_back(exp_res(64'd400000, mk(0, 1, 0), 1'b0, 1'b0));
        send(64'd440000, 5'd1, 1'b1);
        send(64'd480000, 5'd1, 1'b1);
        send(64'd490000, 5'd0, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_valid", 128'(m_valid), 128'(0));
        chk("midrst_start", 128'(m_window_start), 128'(0));
        chk("midrst_counts", 128'(m_counts), 128'(0));
        chk("midrst_flags", 128'({m_overflow, m_resync}), 128'(0));
        chk("midrst_drop", 128'(drop_count), 128'(0));
        void'(sbq.pop_front());
        @(posedge clk); #1;
        rst = 1'b1;
        m_ready = 1'b1;
        idle(3);
        chk("post_rst_no_result", 128'(m_valid), 128'(0));
        send(64'd500000, 5'd0, 1'b1);
        idle(3);
        chk("no_timeout_flush", 128'(m_valid), 128'(0));
        sbq.push_back(exp_res(64'd500000, mk(1, 0, 0), 1'b0, 1'b1));
        send(64'd540000, 5'd2, 1'b1);
        idle(3);

        chk("sb_empty", 128'(sbq.size()), 128'(0));
        chk("sat_sb_empty", 128'(sbq3.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
